// File: rtl/cpu_types_pkg.sv
// MIPS instruction field encodings and ALU operation codes shared by the
// control path and the datapath.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0A,
        SLTIU = 6'h0B,
        ANDI  = 6'h0C,
        ORI   = 6'h0D,
        XORI  = 6'h0E,
        LUI   = 6'h0F,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00,
        SRL  = 6'h02,
        JR   = 6'h08,
        ADD  = 6'h20,
        ADDU = 6'h21,
        SUB  = 6'h22,
        SUBU = 6'h23,
        AND  = 6'h24,
        OR   = 6'h25,
        XOR  = 6'h26,
        NOR  = 6'h27,
        SLT  = 6'h2A,
        SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux select encodings, plus the sequencer state and the
// instruction classes the decoder hands to the sequencer.
package data_path_muxs_pkg;

    typedef enum logic [1:0] {
        SEL_LOAD_NXT_INSTR, SEL_LOAD_BR_ADDR, SEL_LOAD_JMP_ADDR, SEL_LOAD_JR_ADDR
    } pc_mux_input_selection;

    typedef enum logic [1:0] {
        SEL_RESULT, SEL_DLOAD, SEL_NPC, SEL_IMM16_TO_UPPER_32
    } mem_to_reg_mux_selection;

    typedef enum logic {
        SEL_REG_DATA, SEL_IMM16
    } alu_source_mux_selection;

    typedef enum logic [1:0] {
        SEL_RD, SEL_RT, SEL_RETURN_REGISTER
    } reg_dest_mux_selection;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALTED
    } seq_state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW,
        CLS_BEQ, CLS_BNE, CLS_JR, CLS_J, CLS_JAL, CLS_HALT
    } instr_class_t;

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Combinational IR decode: instruction class, ALU operation and the selects
// that depend only on the instruction, not on the sequencer state.
module instr_decoder
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic [5:0]              i_opcode,
    input  logic [5:0]              i_funct,
    output instr_class_t            o_class,
    output aluop_t                  o_alu_op,
    output alu_source_mux_selection o_alu_src_sel,
    output reg_dest_mux_selection   o_wb_dest_sel,
    output mem_to_reg_mux_selection o_wb_mem_to_reg_sel
);

    always_comb begin
        o_class             = CLS_NOP;
        o_alu_op            = ALU_ADD;
        o_alu_src_sel       = SEL_REG_DATA;
        o_wb_dest_sel       = SEL_RD;
        o_wb_mem_to_reg_sel = SEL_RESULT;
        // The halt opcode is configurable, so it outranks the fixed encodings.
        if (i_opcode == HALT_OPCODE) begin
            o_class = CLS_HALT;
        end else begin
            case (i_opcode)
                RTYPE: begin
                    o_class = CLS_ALU_R;
                    case (i_funct)
                        SLL:       o_alu_op = ALU_SLL;
                        SRL:       o_alu_op = ALU_SRL;
                        ADD, ADDU: o_alu_op = ALU_ADD;
                        SUB, SUBU: o_alu_op = ALU_SUB;
                        AND:       o_alu_op = ALU_AND;
                        OR:        o_alu_op = ALU_OR;
                        XOR:       o_alu_op = ALU_XOR;
                        NOR:       o_alu_op = ALU_NOR;
                        SLT:       o_alu_op = ALU_SLT;
                        SLTU:      o_alu_op = ALU_SLTU;
                        JR:        o_class  = CLS_JR;
                        default:   o_class  = CLS_NOP;
                    endcase
                end
                ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI: begin
                    o_class       = CLS_ALU_I;
                    o_alu_src_sel = SEL_IMM16;
                    o_wb_dest_sel = SEL_RT;
                    case (i_opcode)
                        SLTI:    o_alu_op = ALU_SLT;
                        SLTIU:   o_alu_op = ALU_SLTU;
                        ANDI:    o_alu_op = ALU_AND;
                        ORI:     o_alu_op = ALU_OR;
                        XORI:    o_alu_op = ALU_XOR;
                        LUI:     o_wb_mem_to_reg_sel = SEL_IMM16_TO_UPPER_32;
                        default: o_alu_op = ALU_ADD;
                    endcase
                end
                LW: begin
                    o_class       = CLS_LW;
                    o_alu_src_sel = SEL_IMM16;
                end
                SW: begin
                    o_class       = CLS_SW;
                    o_alu_src_sel = SEL_IMM16;
                end
                BEQ: begin
                    o_class  = CLS_BEQ;
                    o_alu_op = ALU_SUB;
                end
                BNE: begin
                    o_class  = CLS_BNE;
                    o_alu_op = ALU_SUB;
                end
                J:       o_class = CLS_J;
                JAL:     o_class = CLS_JAL;
                default: o_class = CLS_NOP;
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle MIPS control FSM: owns the instruction register and sequences
// fetch, decode, execute, memory and writeback for the datapath.
module datapath_sequencer
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [31:0]             imemload,
    input  logic                    ihit,
    input  logic                    dhit,
    input  logic                    zero,
    output logic [31:0]             instr,
    output pc_mux_input_selection   pc_sel,
    output mem_to_reg_mux_selection mem_to_reg_sel,
    output alu_source_mux_selection alu_src_sel,
    output reg_dest_mux_selection   reg_dest_sel,
    output aluop_t                  alu_op,
    output logic                    pc_en,
    output logic                    reg_wen,
    output logic                    imemREN,
    output logic                    dmemREN,
    output logic                    dmemWEN,
    output logic                    halt
);

    seq_state_t              r_state;
    seq_state_t              w_state_next;
    logic [31:0]             r_instr;
    logic                    w_instr_latch;
    instr_class_t            w_class;
    aluop_t                  w_alu_op;
    alu_source_mux_selection w_alu_src_sel;
    reg_dest_mux_selection   w_wb_dest_sel;
    mem_to_reg_mux_selection w_wb_mem_to_reg_sel;

    instr_decoder #(
        .HALT_OPCODE (HALT_OPCODE)
    ) u_decoder (
        .i_opcode            (r_instr[31:26]),
        .i_funct             (r_instr[5:0]),
        .o_class             (w_class),
        .o_alu_op            (w_alu_op),
        .o_alu_src_sel       (w_alu_src_sel),
        .o_wb_dest_sel       (w_wb_dest_sel),
        .o_wb_mem_to_reg_sel (w_wb_mem_to_reg_sel)
    );

    assign instr = r_instr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_instr_latch) begin
                r_instr <= imemload;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_instr_latch  = 1'b0;
        pc_sel         = SEL_LOAD_NXT_INSTR;
        mem_to_reg_sel = SEL_RESULT;
        alu_src_sel    = SEL_REG_DATA;
        reg_dest_sel   = SEL_RD;
        alu_op         = ALU_ADD;
        pc_en          = 1'b0;
        reg_wen        = 1'b0;
        imemREN        = 1'b0;
        dmemREN        = 1'b0;
        dmemWEN        = 1'b0;
        halt           = 1'b0;
        case (r_state)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    w_instr_latch = 1'b1;
                    w_state_next  = DECODE;
                end
            end
            DECODE: begin
                case (w_class)
                    CLS_HALT: w_state_next = HALTED;
                    CLS_J: begin
                        pc_sel       = SEL_LOAD_JMP_ADDR;
                        pc_en        = 1'b1;
                        w_state_next = FETCH;
                    end
                    CLS_JAL: begin
                        pc_sel         = SEL_LOAD_JMP_ADDR;
                        pc_en          = 1'b1;
                        reg_wen        = 1'b1;
                        reg_dest_sel   = SEL_RETURN_REGISTER;
                        mem_to_reg_sel = SEL_NPC;
                        w_state_next   = FETCH;
                    end
                    default: w_state_next = EXECUTE;
                endcase
            end
            EXECUTE: begin
                alu_src_sel = w_alu_src_sel;
                alu_op      = w_alu_op;
                case (w_class)
                    CLS_BEQ, CLS_BNE: begin
                        // Taken when the zero flag matches the branch sense.
                        if ((w_class == CLS_BEQ) == zero) begin
                            pc_sel = SEL_LOAD_BR_ADDR;
                        end
                        pc_en        = 1'b1;
                        w_state_next = FETCH;
                    end
                    CLS_JR: begin
                        pc_sel       = SEL_LOAD_JR_ADDR;
                        pc_en        = 1'b1;
                        w_state_next = FETCH;
                    end
                    CLS_LW, CLS_SW: w_state_next = MEMORY;
                    default:        w_state_next = WRITEBACK;
                endcase
            end
            MEMORY: begin
                dmemREN = (w_class == CLS_LW);
                dmemWEN = (w_class == CLS_SW);
                if (dhit) begin
                    pc_en        = 1'b1;
                    w_state_next = FETCH;
                    if (w_class == CLS_LW) begin
                        reg_wen        = 1'b1;
                        mem_to_reg_sel = SEL_DLOAD;
                        reg_dest_sel   = SEL_RT;
                    end
                end
            end
            WRITEBACK: begin
                pc_en        = 1'b1;
                w_state_next = FETCH;
                // Unknown encodings retire here as a NOP without a register write.
                if (w_class == CLS_ALU_R || w_class == CLS_ALU_I) begin
                    reg_wen        = 1'b1;
                    reg_dest_sel   = w_wb_dest_sel;
                    mem_to_reg_sel = w_wb_mem_to_reg_sel;
                end
            end
            HALTED:  halt = 1'b1;
            default: w_state_next = FETCH;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench for datapath_sequencer: an instruction-level model predicts
// every cycle's control outputs and IR contents from the ISA rules.
module tb_datapath_sequencer;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5;
    localparam int K_BNE = 6, K_JR = 7, K_J = 8, K_JAL = 9, K_NOP = 10, K_HALT = 11;

    typedef struct packed {
        pc_mux_input_selection   pc_sel;
        mem_to_reg_mux_selection m2r;
        alu_source_mux_selection src;
        reg_dest_mux_selection   dest;
        aluop_t                  op;
        logic                    pc_en;
        logic                    reg_wen;
        logic                    imem;
        logic                    dren;
        logic                    dwen;
        logic                    halt;
    } outs_t;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] fn;
        int         kind;
        aluop_t     op;
        string      name;
    } instr_t;

    logic                    CLK;
    logic                    nRST;
    logic [31:0]             imemload;
    logic                    ihit;
    logic                    dhit;
    logic                    zero;
    logic [31:0]             instr;
    pc_mux_input_selection   pc_sel;
    mem_to_reg_mux_selection mem_to_reg_sel;
    alu_source_mux_selection alu_src_sel;
    reg_dest_mux_selection   reg_dest_sel;
    aluop_t                  alu_op;
    logic                    pc_en;
    logic                    reg_wen;
    logic                    imemREN;
    logic                    dmemREN;
    logic                    dmemWEN;
    logic                    halt;

    instr_t      tbl[$];
    logic [31:0] model_ir;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;

    datapath_sequencer #(
        .HALT_OPCODE (6'h3F)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imemload       (imemload),
        .ihit           (ihit),
        .dhit           (dhit),
        .zero           (zero),
        .instr          (instr),
        .pc_sel         (pc_sel),
        .mem_to_reg_sel (mem_to_reg_sel),
        .alu_src_sel    (alu_src_sel),
        .reg_dest_sel   (reg_dest_sel),
        .alu_op         (alu_op),
        .pc_en          (pc_en),
        .reg_wen        (reg_wen),
        .imemREN        (imemREN),
        .dmemREN        (dmemREN),
        .dmemWEN        (dmemWEN),
        .halt           (halt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic outs_t base();
        outs_t e;
        e.pc_sel = SEL_LOAD_NXT_INSTR;
        e.m2r    = SEL_RESULT;
        e.src    = SEL_REG_DATA;
        e.dest   = SEL_RD;
        e.op     = ALU_ADD;
        e.pc_en  = 1'b0;
        e.reg_wen = 1'b0;
        e.imem   = 1'b0;
        e.dren   = 1'b0;
        e.dwen   = 1'b0;
        e.halt   = 1'b0;
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.pc_sel = pc_sel;
        s.m2r    = mem_to_reg_sel;
        s.src    = alu_src_sel;
        s.dest   = reg_dest_sel;
        s.op     = alu_op;
        s.pc_en  = pc_en;
        s.reg_wen = reg_wen;
        s.imem   = imemREN;
        s.dren   = dmemREN;
        s.dwen   = dmemWEN;
        s.halt   = halt;
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add(input logic [5:0] opc, input logic [5:0] fn, input int kind,
                       input aluop_t op, input string name);
        instr_t t;
        t.opc = opc; t.fn = fn; t.kind = kind; t.op = op; t.name = name;
        tbl.push_back(t);
    endtask

    function automatic int find(input string n);
        foreach (tbl[i]) if (tbl[i].name == n) return i;
        return 0;
    endfunction

    // One clock cycle: drive inputs just after the edge, check mid-cycle.
    task automatic step(input logic ih, input logic dh, input logic [31:0] load,
                        input logic z, input outs_t e, input string tag);
        ihit = ih; dhit = dh; imemload = load; zero = z;
        @(negedge CLK);
        check({tag, ".outs"}, {15'd0, sample()}, {15'd0, e});
        check({tag, ".ir"}, instr, model_ir);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        outs_t e;
        e = base();
        e.imem = 1'b1;
        check({tag, ".outs"}, {15'd0, sample()}, {15'd0, e});
        check({tag, ".ir"}, instr, 32'h0);
    endtask

    task automatic run_instr(input int idx, input int wi, input int dw, input int zf,
                             input bit rst_in_mem);
        instr_t      t;
        logic [31:0] word;
        logic [31:0] rnd;
        outs_t       e;
        logic        z;
        logic        taken;
        t   = tbl[idx];
        rnd = $urandom;
        if (t.kind == K_HALT)   word = 32'hFC000000;
        else if (t.opc == 6'h00) word = {6'h00, rnd[25:6], t.fn};
        else                     word = {t.opc, rnd[25:0]};
        $display("txn %0d %s word=%h ihit_wait=%0d dhit_wait=%0d", n_txn, t.name, word, wi, dw);
        n_txn++;

        e = base();
        e.imem = 1'b1;
        for (int i = 0; i < wi; i++) step(1'b0, rb(), $urandom, rb(), e, {t.name, ".fetch_wait"});
        step(1'b1, rb(), word, rb(), e, {t.name, ".fetch"});
        model_ir = word;

        e = base();
        if (t.kind == K_J || t.kind == K_JAL) begin
            e.pc_sel = SEL_LOAD_JMP_ADDR;
            e.pc_en  = 1'b1;
            if (t.kind == K_JAL) begin
                e.reg_wen = 1'b1;
                e.dest    = SEL_RETURN_REGISTER;
                e.m2r     = SEL_NPC;
            end
            step(rb(), rb(), $urandom, rb(), e, {t.name, ".decode"});
            return;
        end
        step(rb(), rb(), $urandom, rb(), e, {t.name, ".decode"});
        if (t.kind == K_HALT) begin
            e = base();
            e.halt = 1'b1;
            for (int i = 0; i < 4; i++) step(1'b1, rb(), $urandom, rb(), e, {t.name, ".halted"});
            return;
        end

        z = (zf == 2) ? rb() : 1'(zf);
        e = base();
        e.op = t.op;
        if (t.kind == K_I || t.kind == K_LUI || t.kind == K_LW || t.kind == K_SW) e.src = SEL_IMM16;
        if (t.kind == K_BEQ || t.kind == K_BNE) begin
            taken   = (t.kind == K_BEQ) ? z : !z;
            e.pc_en = 1'b1;
            if (taken) e.pc_sel = SEL_LOAD_BR_ADDR;
        end
        if (t.kind == K_JR) begin
            e.pc_sel = SEL_LOAD_JR_ADDR;
            e.pc_en  = 1'b1;
        end
        step(rb(), rb(), $urandom, z, e, {t.name, ".execute"});
        if (t.kind == K_BEQ || t.kind == K_BNE || t.kind == K_JR) return;

        if (t.kind == K_LW || t.kind == K_SW) begin
            e = base();
            e.dren = (t.kind == K_LW);
            e.dwen = (t.kind == K_SW);
            if (rst_in_mem) begin
                ihit = 1'b0; dhit = 1'b0;
                #2;
                check({t.name, ".mem_pre_reset"}, {15'd0, sample()}, {15'd0, e});
                nRST = 1'b0;
                #1;
                check_reset({t.name, ".reset_in_mem"});
                @(negedge CLK);
                nRST = 1'b1;
                @(posedge CLK);
                #1;
                model_ir = 32'h0;
                return;
            end
            for (int i = 0; i < dw; i++) step(rb(), 1'b0, $urandom, rb(), e, {t.name, ".mem_wait"});
            e.pc_en = 1'b1;
            if (t.kind == K_LW) begin
                e.reg_wen = 1'b1;
                e.m2r     = SEL_DLOAD;
                e.dest    = SEL_RT;
            end
            step(rb(), 1'b1, $urandom, rb(), e, {t.name, ".mem"});
            return;
        end

        e = base();
        e.pc_en = 1'b1;
        if (t.kind == K_R) e.reg_wen = 1'b1;
        if (t.kind == K_I || t.kind == K_LUI) begin
            e.reg_wen = 1'b1;
            e.dest    = SEL_RT;
        end
        if (t.kind == K_LUI) e.m2r = SEL_IMM16_TO_UPPER_32;
        step(rb(), rb(), $urandom, rb(), e, {t.name, ".writeback"});
    endtask

    initial begin
        outs_t e;
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; imemload = 32'h0;
        model_ir = 32'h0;

        add(6'h00, 6'h21, K_R, ALU_ADD, "ADDU");   add(6'h00, 6'h20, K_R, ALU_ADD, "ADD");
        add(6'h00, 6'h23, K_R, ALU_SUB, "SUBU");   add(6'h00, 6'h22, K_R, ALU_SUB, "SUB");
        add(6'h00, 6'h24, K_R, ALU_AND, "AND");    add(6'h00, 6'h25, K_R, ALU_OR, "OR");
        add(6'h00, 6'h26, K_R, ALU_XOR, "XOR");    add(6'h00, 6'h27, K_R, ALU_NOR, "NOR");
        add(6'h00, 6'h2A, K_R, ALU_SLT, "SLT");    add(6'h00, 6'h2B, K_R, ALU_SLTU, "SLTU");
        add(6'h00, 6'h00, K_R, ALU_SLL, "SLL");    add(6'h00, 6'h02, K_R, ALU_SRL, "SRL");
        add(6'h00, 6'h08, K_JR, ALU_ADD, "JR");    add(6'h00, 6'h01, K_NOP, ALU_ADD, "UNKFN");
        add(6'h08, 6'h00, K_I, ALU_ADD, "ADDI");   add(6'h09, 6'h00, K_I, ALU_ADD, "ADDIU");
        add(6'h0A, 6'h00, K_I, ALU_SLT, "SLTI");   add(6'h0B, 6'h00, K_I, ALU_SLTU, "SLTIU");
        add(6'h0C, 6'h00, K_I, ALU_AND, "ANDI");   add(6'h0D, 6'h00, K_I, ALU_OR, "ORI");
        add(6'h0E, 6'h00, K_I, ALU_XOR, "XORI");   add(6'h0F, 6'h00, K_LUI, ALU_ADD, "LUI");
        add(6'h23, 6'h00, K_LW, ALU_ADD, "LW");    add(6'h2B, 6'h00, K_SW, ALU_ADD, "SW");
        add(6'h04, 6'h00, K_BEQ, ALU_SUB, "BEQ");  add(6'h05, 6'h00, K_BNE, ALU_SUB, "BNE");
        add(6'h02, 6'h00, K_J, ALU_ADD, "J");      add(6'h03, 6'h00, K_JAL, ALU_ADD, "JAL");
        add(6'h3E, 6'h00, K_NOP, ALU_ADD, "UNKOP");
        add(6'h3F, 6'h00, K_HALT, ALU_ADD, "HALT");

        @(posedge CLK);
        #1;
        check_reset("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        run_instr(find("ADDU"), 2, 0, 2, 1'b0);
        run_instr(find("BEQ"), 0, 0, 1, 1'b0);
        run_instr(find("BEQ"), 1, 0, 0, 1'b0);
        run_instr(find("BNE"), 0, 0, 0, 1'b0);
        run_instr(find("BNE"), 0, 0, 1, 1'b0);
        run_instr(find("LW"), 0, 3, 2, 1'b0);
        run_instr(find("SW"), 1, 3, 2, 1'b0);
        run_instr(find("JAL"), 0, 0, 2, 1'b0);
        run_instr(find("LUI"), 0, 0, 2, 1'b0);
        run_instr(find("UNKOP"), 0, 0, 2, 1'b0);

        for (int n = 0; n < 200; n++)
            run_instr($urandom_range(0, tbl.size() - 2), $urandom_range(0, 3),
                      $urandom_range(0, 3), 2, 1'b0);

        run_instr(find("SW"), 0, 0, 2, 1'b1);
        e = base();
        e.imem = 1'b1;
        step(1'b0, 1'b1, $urandom, rb(), e, "SW.post_reset_fetch");

        run_instr(find("HALT"), 0, 0, 2, 1'b0);
        ihit = 1'b0; dhit = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check_reset("HALT.reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        model_ir = 32'h0;
        step(1'b0, rb(), $urandom, rb(), e, "HALT.post_reset_fetch");
        run_instr(find("ADDU"), 0, 0, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
